// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the PC redirect controller.
//   bj_result_t : execute-stage branch/jump decision encoding
//   pc_state_t  : fetch sequencer states
//   PC_INC      : sequential PC increment
//   NOP_INSTR   : instruction presented on IF/ID after reset (addi x0,x0,0)
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BJ_SEQ = 2'b00,
    BJ_REL = 2'b01,
    BJ_RSV = 2'b10,
    BJ_REG = 2'b11
  } bj_result_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } pc_state_t;

  localparam int unsigned PC_INC    = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect-target computation.
//   i_bj_result  : branch/jump decision (only BJ_REL / BJ_REG produce a used target)
//   i_ex_pc      : PC of the execute-stage instruction
//   i_imm        : sign-extended immediate
//   i_alu_result : rs1+imm for JALR
//   o_target     : final redirect target
//   o_misalign   : target had bit[1] set and was replaced by TRAP_VEC
// Optional feature macro: MISALIGN_TRAP_EN (misaligned targets go to TRAP_VEC).
module pc_target_calc
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  bj_result_t        i_bj_result,
  input  logic [XLEN-1:0]   i_ex_pc,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [XLEN-1:0]   i_alu_result,
  output logic [XLEN-1:0]   o_target,
  output logic              o_misalign
);

  logic [XLEN-1:0] raw_target;

  // JALR clears bit 0 of rs1+imm; everything else is PC-relative.
  always_comb begin
    raw_target = i_ex_pc + i_imm;
    if (i_bj_result == BJ_REG) raw_target = i_alu_result & ~XLEN'(1);
  end

`ifdef MISALIGN_TRAP_EN
  assign o_misalign = raw_target[1];
  assign o_target   = o_misalign ? TRAP_VEC : raw_target;
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
  assign o_misalign      = 1'b0;
  assign o_target        = raw_target;
`endif

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: owns the PC, sequences instruction fetch and resolves
// execute-stage redirects against outstanding fetches.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_B_J_result        : 00 seq, 01 PC-relative, 11 JALR, 10 reserved
//   i_ex_valid, i_ex_pc : execute-stage qualifier and PC
//   i_imm, i_alu_result : target operands
//   i_stall             : blocks issue of new fetches
//   o_imem_req/addr, i_imem_ack/rdata : instruction memory handshake
//   o_if_valid/pc/instr : one-cycle delivery into IF/ID
//   o_flush             : one-cycle kill of IF/ID and ID/EX after a redirect
//   o_trap              : misaligned-target pulse
// Optional feature macro: MISALIGN_TRAP_EN (without it o_trap is tied 0).
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_B_J_result,
  input  logic              i_ex_valid,
  input  logic [XLEN-1:0]   i_ex_pc,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic              i_stall,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_rdata,
  output logic              o_if_valid,
  output logic [XLEN-1:0]   o_if_pc,
  output logic [31:0]       o_if_instr,
  output logic              o_flush,
  output logic              o_trap
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic            if_valid_q, if_valid_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            redirect;
  bj_result_t      bj;

  assign bj       = bj_result_t'(i_B_J_result);
  assign redirect = i_ex_valid && ((bj == BJ_REL) || (bj == BJ_REG));

  pc_target_calc #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_target_calc (
    .i_bj_result  (bj),
    .i_ex_pc      (i_ex_pc),
    .i_imm        (i_imm),
    .i_alu_result (i_alu_result),
    .o_target     (target),
    .o_misalign   (misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    if_valid_d = 1'b0;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    flush_d    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
        end
      end
      FETCH: begin
        if (redirect) begin
          flush_d = 1'b1;
          // The request must not be withdrawn: without ack, park the target
          // and keep the current address on the bus until the ack arrives.
          if (i_imem_ack) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = DRAIN;
          end
        end else if (i_imem_ack) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = i_imem_rdata;
          pc_d       = pc_q + XLEN'(PC_INC);
          state_d    = i_stall ? HOLD : FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
          state_d = FETCH;
        end else if (!i_stall) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // EX was flushed, so redirects cannot legally appear here.
        if (i_imem_ack) begin
          pc_d    = tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      flush_q    <= flush_d;
    end
  end

  // Parked target is only read in DRAIN, which is always entered with a fresh write.
  always_ff @(posedge i_clk) begin
    tgt_q <= tgt_d;
  end

  assign o_imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign o_imem_addr = pc_q;
  assign o_if_valid  = if_valid_q;
  assign o_if_pc     = if_pc_q;
  assign o_if_instr  = if_instr_q;
  assign o_flush     = flush_q;

`ifdef MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign trap_d = flush_d && misalign;
  always_ff @(posedge i_clk) begin
    if (i_rst) trap_q <= 1'b0;
    else       trap_q <= trap_d;
  end
  assign o_trap = trap_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign o_trap          = 1'b0;
`endif

  a_no_redirect_in_drain: assert property (
    @(posedge i_clk) disable iff (i_rst) (state_q == DRAIN) |-> !redirect
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  bj = 2'b00;
  logic        exv = 1'b0;
  logic [31:0] expc = '0, imm = '0, alu = '0;
  logic        stall = 1'b0, ack = 1'b0;
  logic [31:0] rdata = '0;

  logic        o_imem_req, o_if_valid, o_flush, o_trap;
  logic [31:0] o_imem_addr, o_if_pc, o_if_instr;

  int n_total = 0;
  int n_bad   = 0;
  int cyc_n   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_B_J_result (bj),
    .i_ex_valid   (exv),
    .i_ex_pc      (expc),
    .i_imm        (imm),
    .i_alu_result (alu),
    .i_stall      (stall),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (ack),
    .i_imem_rdata (rdata),
    .o_if_valid   (o_if_valid),
    .o_if_pc      (o_if_pc),
    .o_if_instr   (o_if_instr),
    .o_flush      (o_flush),
    .o_trap       (o_trap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Fetch-level view: is a request on the bus, is a redirect parked behind it,
  // and what are the address and the last delivery.
  bit          m_fresh, m_req, m_pend;
  logic [31:0] m_pc, m_pend_tgt;
  bit          e_ifv, e_flush, e_trap;
  logic [31:0] e_ifpc, e_instr;

  function automatic logic [31:0] raw_tgt(input logic [1:0] b, input logic [31:0] p,
                                          input logic [31:0] i, input logic [31:0] a);
    if (b == 2'b01) return p + i;
    return {a[31:1], 1'b0};
  endfunction

  always @(posedge clk) begin
    logic [31:0] t;
    bit redir, hit, mis;
    if (rst) begin
      m_fresh = 1; m_req = 0; m_pend = 0; m_pc = 32'h0;
      e_ifv = 0; e_ifpc = 32'h0; e_instr = NOP; e_flush = 0; e_trap = 0;
    end else begin
      redir = exv && (bj == 2'b01 || bj == 2'b11) && !m_pend;
      t     = raw_tgt(bj, expc, imm, alu);
      mis   = 0;
`ifdef MISALIGN_TRAP_EN
      if (t[1]) begin t = 32'h0000_0100; mis = 1; end
`endif
      hit     = m_req && ack;
      e_ifv   = 0;
      e_flush = redir;
      e_trap  = redir && mis;
      if (m_pend) begin
        if (hit) begin m_pc = m_pend_tgt; m_pend = 0; end
      end else if (redir) begin
        if (m_req && !hit) begin m_pend = 1; m_pend_tgt = t; end
        else begin m_pc = t; m_req = 1; end
      end else if (m_fresh) begin
        m_req = 1;
      end else if (m_req) begin
        if (hit) begin
          e_ifv = 1; e_ifpc = m_pc; e_instr = rdata;
          m_pc = m_pc + 32'd4;
          m_req = !stall;
        end
      end else if (!stall) begin
        m_req = 1;
      end
      m_fresh = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req",  32'(o_imem_req), 32'(m_req));
      chk("imem_addr", o_imem_addr,     m_pc);
      chk("if_valid",  32'(o_if_valid), 32'(e_ifv));
      chk("if_pc",     o_if_pc,         e_ifpc);
      chk("if_instr",  o_if_instr,      e_instr);
      chk("flush",     32'(o_flush),    32'(e_flush));
      chk("trap",      32'(o_trap),     32'(e_trap));
    end
  end

  task automatic step(input logic a, input logic s, input logic v, input logic [1:0] b,
                      input logic [31:0] p, input logic [31:0] i, input logic [31:0] al);
    ack = a; stall = s; exv = v; bj = b; expc = p; imm = i; alu = al;
    rdata = 32'hC0DE_0000 + 32'(cyc_n);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    rst = 1'b1;
    step(1, 0, 0, 2'b00, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("rst_req",   32'(o_imem_req), 32'h0);
    chk("rst_addr",  o_imem_addr,     32'h0);
    chk("rst_instr", o_if_instr,      NOP);
    rst = 1'b0;
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("first_req",  32'(o_imem_req), 32'h1);
    chk("first_addr", o_imem_addr,     32'h0);
    // back-to-back sequential fetches
    step(1, 0, 0, 2'b00, 0, 0, 0);
    chk("seq0_pc",   o_if_pc,     32'h0);
    chk("seq0_next", o_imem_addr, 32'h4);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    chk("seq1_next", o_imem_addr, 32'h8);
    // stall two cycles after ack at 0x8
    step(1, 1, 0, 2'b00, 0, 0, 0);
    chk("stall_pc",   o_if_pc,         32'h8);
    chk("stall_req0", 32'(o_imem_req), 32'h0);
    step(0, 1, 0, 2'b00, 0, 0, 0);
    chk("stall_req1", 32'(o_imem_req), 32'h0);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("resume_addr", o_imem_addr, 32'hC);
    // PC-relative redirect together with ack
    step(1, 0, 1, 2'b01, 32'h10, 32'h20, 0);
    chk("rel_valid", 32'(o_if_valid), 32'h0);
    chk("rel_flush", 32'(o_flush),    32'h1);
    chk("rel_addr",  o_imem_addr,     32'h30);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("rel_flush_off", 32'(o_flush), 32'h0);
    // JALR redirect while the fetch is still waiting
    step(0, 0, 1, 2'b11, 0, 0, 32'h45);
    chk("jalr_hold_addr", o_imem_addr, 32'h30);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("jalr_hold_addr2", o_imem_addr, 32'h30);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    chk("jalr_addr",  o_imem_addr,     32'h44);
    chk("jalr_valid", 32'(o_if_valid), 32'h0);
    // reserved code and unqualified decision have no effect
    step(1, 0, 1, 2'b10, 32'h800, 32'h40, 32'h900);
    chk("rsv_addr", o_imem_addr, 32'h48);
    step(1, 0, 0, 2'b01, 32'h800, 32'h40, 32'h900);
    chk("noval_addr", o_imem_addr, 32'h4C);
    // redirect out of HOLD wins over stall
    step(1, 1, 0, 2'b00, 0, 0, 0);
    step(0, 1, 1, 2'b01, 32'h200, 32'hFFFF_FFF8, 0);
    chk("hold_redir", o_imem_addr, 32'h1F8);
    // wrap-around targets
    step(1, 0, 1, 2'b01, 32'hFFFF_FFFC, 32'h8, 0);
    chk("wrap_addr", o_imem_addr, 32'h4);
    step(1, 0, 1, 2'b01, 32'hFFFF_FFFC, 32'h6, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_addr", o_imem_addr,  32'h100);
    chk("mis_trap", 32'(o_trap),  32'h1);
`else
    chk("mis_addr", o_imem_addr,  32'h2);
    chk("mis_trap", 32'(o_trap),  32'h0);
`endif
    step(1, 0, 1, 2'b11, 0, 0, 32'hFFFF_FFF9);
    chk("jalr_hi", o_imem_addr, 32'hFFFF_FFF8);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    chk("pc_wrap", o_imem_addr, 32'h0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    // reset with an outstanding fetch acked in the same cycle
    rst = 1'b1;
    step(1, 0, 0, 2'b00, 0, 0, 0);
    chk("rstmid_valid", 32'(o_if_valid), 32'h0);
    chk("rstmid_addr",  o_imem_addr,     32'h0);
    chk("rstmid_req",   32'(o_imem_req), 32'h0);
    rst = 1'b0;
    step(0, 0, 0, 2'b00, 0, 0, 0);
    chk("rstmid_refetch", o_imem_addr, 32'h0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    chk("rstmid_pc", o_if_pc, 32'h0);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
